// File: rtl/cond_jump_pc.sv
// Program counter with conditional jump on the sign/zero/positive state of an ALU result.
// A halt state is entered by an unconditional jump-to-self and is left only through load or reset.
module cond_jump_pc #(
  parameter int unsigned       WIDTH    = 16,
  parameter logic [WIDTH-1:0]  RESET_PC = '0,
  parameter int unsigned       CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             jump_valid,
  input  logic [2:0]       cond,
  input  logic [WIDTH-1:0] value,
  input  logic [WIDTH-1:0] target,
  input  logic             load,
  input  logic [WIDTH-1:0] load_addr,
  output logic [WIDTH-1:0] pc,
  output logic             taken,
  output logic             halted,
  output logic [CNT_W-1:0] jump_count
);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] pc_q;
  logic             taken_q;
  logic [CNT_W-1:0] cnt_q;

  logic neg, zero, pos, cond_true, take, halt_entry;

  always_comb begin
    neg        = value[WIDTH-1];
    zero       = (value == '0);
    pos        = !neg && !zero;
    cond_true  = (cond[2] & neg) | (cond[1] & zero) | (cond[0] & pos);
    take       = (state_q == StRun) && step && jump_valid && cond_true;
    // Only an unconditional jump-to-self halts; a conditional one just re-executes.
    halt_entry = take && (cond == 3'b111) && (target == pc_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      taken_q <= 1'b0;
      cnt_q   <= '0;
      state_q <= StRun;
    end else if (load) begin
      pc_q    <= load_addr;
      taken_q <= 1'b0;
      state_q <= StRun;
    end else if (state_q == StHalt) begin
      taken_q <= 1'b0;
    end else if (take) begin
      pc_q    <= target;
      taken_q <= 1'b1;
      if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
      if (halt_entry) state_q <= StHalt;
    end else if (step) begin
      pc_q    <= pc_q + WIDTH'(1);
      taken_q <= 1'b0;
    end else begin
      taken_q <= 1'b0;
    end
  end

  assign pc         = pc_q;
  assign taken      = taken_q;
  assign halted     = (state_q == StHalt);
  assign jump_count = cnt_q;

endmodule

// File: tb/tb_cond_jump_pc.sv
// Randomised and directed bench for cond_jump_pc against an arithmetic reference model.
module tb_cond_jump_pc;

  localparam int CNT_W = 2;
  localparam int MAX_CNT = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        step = 1'b0, jump_valid = 1'b0, load = 1'b0;
  logic [2:0]  cond = 3'b000;
  logic [15:0] value = '0, target = '0, load_addr = '0;
  logic [15:0] pc;
  logic        taken, halted;
  logic [CNT_W-1:0] jump_count;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int m_pc = 0;
  int m_cnt = 0;
  bit m_taken = 0;
  bit m_halt = 0;

  cond_jump_pc #(.WIDTH(16), .RESET_PC(16'h0000), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .step(step), .jump_valid(jump_valid), .cond(cond),
    .value(value), .target(target), .load(load), .load_addr(load_addr),
    .pc(pc), .taken(taken), .halted(halted), .jump_count(jump_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit cond_holds(input logic [2:0] c, input logic [15:0] v);
    int sv;
    sv = int'($signed(v));
    return (c[2] && sv < 0) || (c[1] && sv == 0) || (c[0] && sv > 0);
  endfunction

  task automatic model_edge();
    if (load) begin
      m_pc = int'(load_addr); m_halt = 0; m_taken = 0;
    end else if (m_halt) begin
      m_taken = 0;
    end else if (step && jump_valid && cond_holds(cond, value)) begin
      if (cond == 3'b111 && int'(target) == m_pc) m_halt = 1;
      m_pc = int'(target); m_taken = 1;
      if (m_cnt < MAX_CNT) m_cnt++;
    end else if (step) begin
      m_pc = (m_pc + 1) % 65536; m_taken = 0;
    end else begin
      m_taken = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"}, 32'(pc), 32'(m_pc));
    chk({tag, ".taken"}, 32'(taken), 32'(m_taken));
    chk({tag, ".halted"}, 32'(halted), 32'(m_halt));
    chk({tag, ".cnt"}, 32'(jump_count), 32'(m_cnt));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic ld, input logic [15:0] la, input logic st, input logic jv,
                       input logic [2:0] c, input logic [15:0] v, input logic [15:0] tg);
    load = ld; load_addr = la; step = st; jump_valid = jv; cond = c; value = v; target = tg;
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    m_pc = 0; m_cnt = 0; m_taken = 0; m_halt = 0;
    check_all(tag);
    #1 rst = 1'b0;
  endtask

  logic [2:0]  ct [6] = '{3'b100, 3'b100, 3'b010, 3'b001, 3'b001, 3'b000};
  logic [15:0] vt [6] = '{16'h8000, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'h1234};
  logic [15:0] et [6] = '{16'h0100, 16'h0011, 16'h0100, 16'h0100, 16'h0011, 16'h0011};

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick("hold");

    drive(1, 16'hFFFE, 0, 0, 0, 0, 0);
    tick("load_fffe");
    drive(0, 0, 1, 0, 3'b111, 0, 16'h1234);
    for (int i = 0; i < 3; i++) tick("seq_step");
    chk("wrap_pc", 32'(pc), 32'h0001);

    for (int i = 0; i < 6; i++) begin
      drive(1, 16'h0010, 0, 0, 0, 0, 0);
      tick("mat_load");
      drive(0, 0, 1, 1, ct[i], vt[i], 16'h0100);
      tick("mat_jump");
      chk("mat_pc", 32'(pc), 32'(et[i]));
      chk("mat_taken", 32'(taken), 32'(et[i] == 16'h0100));
      drive(0, 0, 0, 0, 0, 0, 0);
      tick("mat_after");
    end

    drive(1, 16'h0020, 0, 0, 0, 0, 0);
    tick("halt_load");
    drive(0, 0, 1, 1, 3'b111, 16'h0055, 16'h0020);
    tick("halt_enter");
    chk("halt_flag", 32'(halted), 32'h1);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 1, 3'b111, 16'($urandom), 16'($urandom));
      tick("halt_stay");
    end
    chk("halt_pc", 32'(pc), 32'h0020);
    chk("halt_taken", 32'(taken), 32'h0);
    drive(1, 16'h0005, 0, 0, 0, 0, 0);
    tick("halt_exit");
    chk("halt_exit_pc", 32'(pc), 32'h0005);
    chk("halt_exit_flag", 32'(halted), 32'h0);

    drive(1, 16'h0077, 1, 1, 3'b111, 0, 16'h0100);
    tick("prio");
    chk("prio_pc", 32'(pc), 32'h0077);
    chk("prio_taken", 32'(taken), 32'h0);

    async_reset("rst_pre_sat");
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 1, 3'b111, 16'h0001, 16'(16'h0200 + i));
      tick("sat_jump");
    end
    chk("sat_cnt", 32'(jump_count), 32'(MAX_CNT));
    async_reset("rst_mid");
    chk("rst_mid_pc", 32'(pc), 32'h0);

    for (int n = 0; n < 3000; n++) begin
      logic [15:0] v, tg;
      logic [2:0]  c;
      case ($urandom_range(0, 3))
        0: v = 16'h0000;
        1: v = 16'h8000;
        2: v = 16'h7FFF;
        default: v = 16'($urandom);
      endcase
      c  = 3'($urandom);
      tg = 16'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        c = 3'b111; tg = 16'(m_pc);
      end else if ($urandom_range(0, 15) == 0) begin
        tg = 16'(m_pc);
      end
      drive(($urandom_range(0, 19) == 0), 16'($urandom), 1'($urandom), 1'($urandom), c, v, tg);
      if ($urandom_range(0, 199) == 0) begin
        drive(0, 0, 0, 0, 0, 0, 0);
        async_reset("rnd_rst");
      end else begin
        tick("rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cond_jump_pc.md
Name: cond_jump_pc

Overview:
- Sequential program-counter / conditional-jump unit for the 16-bit CPU.
- Consumes a signed ALU result and derives its sign, zero and positive conditions internally; sign is bit [WIDTH-1] of the value.
- Combines those conditions with the instruction's lt/eq/gt mask to either jump or step the PC.
- Tracks a halted state (unconditional jump-to-self) and counts taken jumps for debug.

Parameters:
- WIDTH, 16, data/address width of value, target, load_addr and pc.
- RESET_PC, 0, pc value after reset.
- CNT_W, 8, width of taken-jump counter; the counter saturates.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- step  input  1  advance one instruction this cycle.
- jump_valid  input  1  the current instruction is a jump; qualified by step.
- cond  input  3  jump mask {lt, eq, gt}; bit 2 = lt, bit 1 = eq, bit 0 = gt.
- value  input  WIDTH  signed ALU result tested by the condition.
- target  input  WIDTH  jump destination.
- load  input  1  force pc to load_addr; highest priority.
- load_addr  input  WIDTH  address used by load.
- pc  output  WIDTH  current program counter.
- taken  output  1  registered one-cycle pulse: a jump was taken on the previous edge.
- halted  output  1  high while the FSM is in HALT.
- jump_count  output  CNT_W  number of taken jumps since reset, saturating.

Behaviour:
- Reset (async, rst=1): pc=RESET_PC, taken=0, halted=0, jump_count=0, state=RUN. Asserting rst mid-operation takes effect immediately, without waiting for a clock edge.
- Conditions are combinational from value:
  - neg = value[WIDTH-1]
  - zero = (value == 0)
  - pos = !neg && !zero
  - exactly one of neg/zero/pos is 1.
- cond_true = (cond[2]&neg) | (cond[1]&zero) | (cond[0]&pos).
  - cond = 3'b000 never jumps.
  - cond = 3'b111 always jumps.
- take = state==RUN && step && jump_valid && cond_true.
- Per-edge priority:
  1. load: pc <= load_addr, state <= RUN. Clears HALT; step is ignored that cycle; taken <= 0.
  2. state==HALT: pc holds; step and jump_valid are ignored; taken <= 0.
  3. take: pc <= target, taken <= 1, jump_count <= jump_count+1 unless already all-ones.
  4. step (jump not taken or not a jump): pc <= pc+1 modulo 2^WIDTH, so 0xFFFF wraps to 0x0000; taken <= 0.
  5. otherwise: all registers hold; taken <= 0.
- HALT entry: take && cond==3'b111 && target==pc. On that edge:
  - pc <= target (unchanged value), taken <= 1, jump_count increments, state <= HALT.
  - halted is 1 from the following cycle.
- A conditional jump-to-self (cond != 3'b111) does not halt; it simply re-executes.
- HALT exit: only via load or rst.
- Latency: one edge from step to pc update; taken and halted are registered outputs with no combinational path from inputs.
- jump_valid without step has no effect.

Test Plan:
- Reset then hold: rst pulse, step=0 for 3 cycles -> pc=0, taken=0, halted=0, jump_count=0 throughout.
- Sequential step with wrap: load load_addr=16'hFFFE, then 3 steps with jump_valid=0 -> pc 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001; taken stays 0.
- Condition matrix: pc=16'h0010, target=16'h0100, step=1, jump_valid=1:
  - cond=3'b100, value=16'h8000 -> pc=16'h0100, taken=1 for one cycle.
  - cond=3'b100, value=16'h0000 -> pc=16'h0011.
  - cond=3'b010, value=0 -> jump.
  - cond=3'b001, value=16'h7FFF -> jump.
  - cond=3'b001, value=0 -> no jump.
  - cond=3'b000 with any value -> pc+1.
- Halt: pc=16'h0020, cond=3'b111, target=16'h0020, step -> halted=1 next cycle. Further steps with any jump keep pc=16'h0020 and taken=0. Then load load_addr=16'h0005 -> halted=0, pc=16'h0005.
- Priority: load=1 with a simultaneous true jump -> pc=load_addr, taken=0, jump_count unchanged.
- Counter saturation and async reset: CNT_W=2, 5 taken jumps -> jump_count=3. Assert rst between clock edges -> all outputs clear before the next edge.
